conv_systolic_array_kxk: RTL and testbench
==========================================

// Module: conv_systolic_array_kxk
// PURPOSE
//  Parametrised KxK systolic convolution engine computing NUM_F filters per window in parallel.
//  Weights are streamed in serially and held. Windows arrive over a valid/ready handshake.
//  Results leave through a stallable valid/ready output, with optional ReLU.
//  Sits between the line-buffer/window generator and the output feature-map writer.
// PARAMETERS
//  K            3   kernel edge; window and filter are KxK (K>=2)
//  NUM_F        2   filters (output channels) computed per window
//  DATA_WIDTH   16  signed window element width
//  WEIGHT_WIDTH 8   signed weight width
//  ACCUM_WIDTH  32  signed accumulator/result width
// PORTS
//  clk          in   1                    rising-edge clock
//  rst_n        in   1                    asynchronous active-low reset
//  w_start      in   1                    pulse: begin weight load
//  w_valid      in   1                    weight beat valid
//  w_ready      out  1                    high while in LOAD
//  w_data       in   WEIGHT_WIDTH         weight beat
//  w_last       in   1                    marks final weight beat
//  load_err     out  1                    sticky: bad load length; cleared by next w_start
//  weights_ok   out  1                    high in RUN
//  win_valid    in   1                    window valid
//  win_ready    out  1                    window accepted when win_valid&&win_ready
//  window_flat  in   K*K*DATA_WIDTH       element k=row*K+col at [(k+1)*DATA_WIDTH-1 -: DATA_WIDTH]
//  relu_en      in   1                    sampled with window; clamp negative results to 0
//  out_valid    out  1                    result valid
//  out_ready    in   1                    downstream accepts
//  result_flat  out  NUM_F*ACCUM_WIDTH    filter f at [(f+1)*ACCUM_WIDTH-1 -: ACCUM_WIDTH]
// BEHAVIOUR
//  Reset: state EMPTY; all weights, pipeline regs, result_flat, load_err cleared.
//    Outputs w_ready, weights_ok, win_ready, out_valid = 0.
//  FSM EMPTY/LOAD/RUN.
//    w_start in EMPTY, or in RUN with pipeline empty and out_valid=0 -> LOAD, beat counter=0, load_err=0.
//    w_start in any other case is ignored.
//  LOAD: each w_valid beat writes weight[cnt], cnt++.
//    Order: filter-major, then row-major (index f*K*K + row*K + col).
//    TOTAL = NUM_F*K*K. The beat with cnt==TOTAL-1 -> RUN, whether or not w_last is set.
//    w_last on a beat with cnt<TOTAL-1 -> load_err=1, state EMPTY, weights invalid.
//  win_ready = (state==RUN) && !(out_valid && !out_ready).
//  Datapath: KxK PE grid, row r fed with window row r.
//    Data and partial sums move left->right one PE per cycle; inputs are skewed internally.
//    Each PE computes product = signed data * signed weight (DATA_WIDTH+WEIGHT_WIDTH bits),
//    sign-extended to ACCUM_WIDTH. Accumulation wraps in two's complement; no saturation.
//  Final stage: sums the K row results per filter; if the relu_en tag is set, negatives become 0.
//  Latency: out_valid rises after K+1 rising edges, counting the accepting edge as edge 1 (K=3 -> 4).
//  Throughput: one window per cycle. Results leave in acceptance order.
//  Stall: out_valid && !out_ready freezes every pipeline stage; result_flat is held stable.
//    No window is dropped or duplicated.
//  A simultaneous out handshake and new window acceptance in the same cycle is legal.
//    The pipeline advances normally.
//  relu_en travels with its window, so mode changes between windows take effect per window.
//  rst_n low mid-stream: in-flight windows are discarded and out_valid drops asynchronously.
//    A full reload is required afterwards.
// TESTING (K=3, NUM_F=2, defaults)
//  Load f0 all 1, f1 = 1 at index 4 (else 0). Window 1..9, out_ready=1
//    -> weights_ok=1; result f0=45, f1=5; out_valid on 4th edge.
//  Window all -2, f0 all 3: relu_en=0 -> f0=-54; relu_en=1 -> f0=0.
//  10 back-to-back windows, out_ready low for 3 cycles mid-stream
//    -> win_ready low during the stall; all 10 results in order; result_flat stable while stalled.
//  w_start then w_last on beat 10 of 18 -> load_err=1, state EMPTY, win_ready=0.
//    Next w_start clears load_err.
//  w_start while windows are in flight -> ignored, results unchanged. w_start after drain -> w_ready=1.
//  rst_n pulsed with 2 windows in flight -> out_valid=0 immediately, weights_ok=0, no stale result after reload.

Source files
------------

// File: rtl/conv_systolic_array_kxk.sv
// rtl/conv_systolic_array_kxk.sv - KxK systolic convolution engine, NUM_F filters per window
module conv_systolic_array_kxk #(
    parameter int K            = 3,
    parameter int NUM_F        = 2,
    parameter int DATA_WIDTH   = 16,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACCUM_WIDTH  = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            w_start,
    input  logic                            w_valid,
    output logic                            w_ready,
    input  logic [WEIGHT_WIDTH-1:0]         w_data,
    input  logic                            w_last,
    output logic                            load_err,
    output logic                            weights_ok,
    input  logic                            win_valid,
    output logic                            win_ready,
    input  logic [K*K*DATA_WIDTH-1:0]       window_flat,
    input  logic                            relu_en,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_F*ACCUM_WIDTH-1:0]    result_flat
);
    localparam int TOTAL = NUM_F * K * K;
    localparam int CW    = $clog2(TOTAL);

    typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_RUN} state_t;

    state_t                          state_q, state_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic                            load_err_q, load_err_d;
    logic signed [WEIGHT_WIDTH-1:0]  weight_q [TOTAL];

    // Stage c holds the window seen by PE column c; psum_q[c] is the row partial sum after column c.
    logic [K*K*DATA_WIDTH-1:0]       win_q [K];
    logic [K-1:0]                    vld_q, relu_q;
    logic signed [ACCUM_WIDTH-1:0]   psum_q [K-1][NUM_F][K];
    logic signed [ACCUM_WIDTH-1:0]   psum_d [K-1][NUM_F][K];
    logic [NUM_F*ACCUM_WIDTH-1:0]    result_q, result_d;
    logic                            out_valid_q;
    logic                            adv, accept, pipe_empty;

    function automatic logic signed [ACCUM_WIDTH-1:0] mac(
        input logic signed [DATA_WIDTH-1:0]   d,
        input logic signed [WEIGHT_WIDTH-1:0] w
    );
        logic signed [DATA_WIDTH+WEIGHT_WIDTH-1:0] p;
        p = d * w;
        return ACCUM_WIDTH'(p);
    endfunction

    assign adv         = !(out_valid_q && !out_ready);
    assign pipe_empty  = (vld_q == '0) && !out_valid_q;
    assign win_ready   = (state_q == S_RUN) && adv;
    assign accept      = win_valid && win_ready;
    assign w_ready     = (state_q == S_LOAD);
    assign weights_ok  = (state_q == S_RUN);
    assign load_err    = load_err_q;
    assign out_valid   = out_valid_q;
    assign result_flat = result_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_err_d = load_err_q;
        case (state_q)
            S_EMPTY: begin
                if (w_start) begin
                    state_d    = S_LOAD;
                    cnt_d      = '0;
                    load_err_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (w_valid) begin
                    if (cnt_q == CW'(TOTAL - 1)) begin
                        state_d = S_RUN;
                    end else if (w_last) begin
                        state_d    = S_EMPTY;
                        load_err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (w_start && pipe_empty) begin
                    state_d    = S_LOAD;
                    cnt_d      = '0;
                    load_err_d = 1'b0;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            cnt_q      <= '0;
            load_err_q <= 1'b0;
            for (int i = 0; i < TOTAL; i++) weight_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            load_err_q <= load_err_d;
            if (state_q == S_LOAD && w_valid) weight_q[cnt_q] <= w_data;
        end
    end

    always_comb begin
        psum_d   = psum_q;
        result_d = '0;
        for (int c = 0; c < K - 1; c++) begin
            for (int f = 0; f < NUM_F; f++) begin
                for (int r = 0; r < K; r++) begin
                    psum_d[c][f][r] = ((c == 0) ? '0 : psum_q[(c == 0) ? 0 : c - 1][f][r])
                                    + mac(win_q[c][(r*K+c)*DATA_WIDTH +: DATA_WIDTH],
                                          weight_q[f*K*K + r*K + c]);
                end
            end
        end
        // Last column feeds straight into the row adder tree and ReLU.
        for (int f = 0; f < NUM_F; f++) begin
            logic signed [ACCUM_WIDTH-1:0] acc;
            acc = '0;
            for (int r = 0; r < K; r++) begin
                acc = acc + psum_q[K-2][f][r]
                    + mac(win_q[K-1][(r*K+K-1)*DATA_WIDTH +: DATA_WIDTH],
                          weight_q[f*K*K + r*K + K - 1]);
            end
            if (relu_q[K-1] && acc[ACCUM_WIDTH-1]) acc = '0;
            result_d[f*ACCUM_WIDTH +: ACCUM_WIDTH] = acc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            relu_q      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            for (int c = 0; c < K; c++) win_q[c] <= '0;
            for (int c = 0; c < K - 1; c++)
                for (int f = 0; f < NUM_F; f++)
                    for (int r = 0; r < K; r++) psum_q[c][f][r] <= '0;
        end else if (adv) begin
            vld_q    <= {vld_q[K-2:0], accept};
            relu_q   <= {relu_q[K-2:0], relu_en};
            win_q[0] <= window_flat;
            for (int c = 1; c < K; c++) win_q[c] <= win_q[c-1];
            psum_q      <= psum_d;
            out_valid_q <= vld_q[K-1];
            if (vld_q[K-1]) result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_conv_systolic_array_kxk.sv
// tb/tb_conv_systolic_array_kxk.sv - scoreboard bench for conv_systolic_array_kxk
module tb_conv_systolic_array_kxk;
    localparam int K = 3, NF = 2, DW = 16, WW = 8, AW = 32, NE = K * K, TOTAL = NF * NE;

    logic clk, rst_n;
    logic w_start, w_valid, w_ready, w_last, load_err, weights_ok;
    logic [WW-1:0] w_data;
    logic win_valid, win_ready, relu_en, out_valid, out_ready;
    logic [NE*DW-1:0] window_flat;
    logic [NF*AW-1:0] result_flat;

    conv_systolic_array_kxk #(.K(K), .NUM_F(NF), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACCUM_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .w_start(w_start), .w_valid(w_valid), .w_ready(w_ready),
        .w_data(w_data), .w_last(w_last), .load_err(load_err), .weights_ok(weights_ok),
        .win_valid(win_valid), .win_ready(win_ready), .window_flat(window_flat), .relu_en(relu_en),
        .out_valid(out_valid), .out_ready(out_ready), .result_flat(result_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef int elems_t [NE];
    typedef struct { elems_t e; bit relu; int e0; int e1; } vec_t;

    vec_t t1 [6];
    vec_t t2 [3];
    int tb_w [TOTAL];
    logic [NF*AW-1:0] q_exp [$];
    int n_cmp = 0, n_bad = 0;
    bit mon_en = 0, held_v = 0;
    logic [NF*AW-1:0] held_r;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int a0, input int a1);
        return {a1, a0};
    endfunction

    function automatic logic [NE*DW-1:0] mkwin(input elems_t e);
        logic [NE*DW-1:0] w;
        int v;
        for (int k = 0; k < NE; k++) begin
            v = e[k];
            w[k*DW +: DW] = v[DW-1:0];
        end
        return w;
    endfunction

    function automatic logic [63:0] model(input elems_t e, input bit relu);
        int s [NF];
        for (int f = 0; f < NF; f++) begin
            s[f] = 0;
            for (int k = 0; k < NE; k++) s[f] += e[k] * tb_w[f*NE + k];
            if (relu && s[f] < 0) s[f] = 0;
        end
        return pk(s[0], s[1]);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (held_v) chk("stall_hold", result_flat, held_r);
            if (out_valid && out_ready) begin
                if (q_exp.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got %0h expected none", result_flat);
                end else begin
                    chk("result", result_flat, q_exp.pop_front());
                end
            end
            held_v <= out_valid && !out_ready;
            held_r <= result_flat;
        end else begin
            held_v <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NE*DW-1:0] w, input bit r, input logic [63:0] e);
        bit got;
        int guard;
        guard = 0;
        win_valid = 1'b1;
        window_flat = w;
        relu_en = r;
        forever begin
            @(negedge clk);
            got = win_ready;
            @(posedge clk);
            if (got) begin
                q_exp.push_back(e);
                break;
            end
            guard++;
            if (guard > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: got win_ready=0 expected 1");
                break;
            end
        end
        #1;
        win_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((q_exp.size() != 0 || out_valid) && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("drain_queue", q_exp.size(), 0);
        tick();
    endtask

    task automatic load_w(input int n);
        tick();
        w_start = 1'b1;
        tick();
        w_start = 1'b0;
        chk("load_w_ready", w_ready, 1);
        chk("load_err_cleared", load_err, 0);
        for (int i = 0; i < n; i++) begin
            w_valid = 1'b1;
            w_data = WW'(tb_w[i]);
            w_last = (i == n - 1);
            tick();
        end
        w_valid = 1'b0;
        w_last = 1'b0;
        chk("load_weights_ok", weights_ok, (n == TOTAL));
        chk("load_err_flag", load_err, (n != TOTAL));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        elems_t e;
        bit r, seen;
        t1[0] = '{e: '{1, 2, 3, 4, 5, 6, 7, 8, 9}, relu: 1'b0, e0: 45, e1: 5};
        t1[1] = '{e: '{default: -2}, relu: 1'b0, e0: -18, e1: -2};
        t1[2] = '{e: '{default: -2}, relu: 1'b1, e0: 0, e1: 0};
        t1[3] = '{e: '{100, -3, 7, 0, -50, 2, -1, 1, 4}, relu: 1'b0, e0: 60, e1: -50};
        t1[4] = '{e: '{100, -3, 7, 0, -50, 2, -1, 1, 4}, relu: 1'b1, e0: 60, e1: 0};
        t1[5] = '{e: '{default: 32767}, relu: 1'b0, e0: 294903, e1: 32767};
        t2[0] = '{e: '{default: -2}, relu: 1'b0, e0: -54, e1: 18};
        t2[1] = '{e: '{default: -2}, relu: 1'b1, e0: 0, e1: 18};
        t2[2] = '{e: '{default: 5}, relu: 1'b1, e0: 135, e1: 0};

        rst_n = 1'b0; w_start = 0; w_valid = 0; w_last = 0; w_data = '0;
        win_valid = 0; window_flat = '0; relu_en = 0; out_ready = 1'b1;
        #12;
        chk("rst_w_ready", w_ready, 0);
        chk("rst_weights_ok", weights_ok, 0);
        chk("rst_win_ready", win_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_load_err", load_err, 0);
        chk("rst_result", result_flat, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < TOTAL; i++) tb_w[i] = (i < NE) ? 1 : ((i == NE + 4) ? 1 : 0);
        load_w(TOTAL);
        send(mkwin(t1[0].e), 1'b0, pk(45, 5));
        @(negedge clk); chk("lat_edge1", out_valid, 0);
        @(negedge clk);
        @(negedge clk); chk("lat_edge3", out_valid, 0);
        @(negedge clk); chk("lat_edge4", out_valid, 1);
        drain();
        for (int i = 0; i < 6; i++) send(mkwin(t1[i].e), t1[i].relu, pk(t1[i].e0, t1[i].e1));
        drain();

        for (int i = 0; i < TOTAL; i++) tb_w[i] = (i < NE) ? 3 : -1;
        load_w(TOTAL);
        for (int i = 0; i < 3; i++) send(mkwin(t2[i].e), t2[i].relu, pk(t2[i].e0, t2[i].e1));
        drain();

        fork
            begin
                for (int n = 0; n < 10; n++) begin
                    for (int k = 0; k < NE; k++) e[k] = int'($urandom_range(2000)) - 1000;
                    r = 1'($urandom_range(1));
                    send(mkwin(e), r, model(e, r));
                end
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_win_ready", win_ready, 0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        load_w(10);
        chk("err_win_ready", win_ready, 0);
        chk("err_w_ready", w_ready, 0);
        for (int i = 0; i < TOTAL; i++) tb_w[i] = (i < NE) ? -128 : 127;
        load_w(TOTAL);
        send(mkwin('{default: -32768}), 1'b0, pk(37748736, -37453824));
        send(mkwin('{default: 32767}), 1'b0, pk(-37747584, 37452681));

        send(mkwin(t1[0].e), 1'b0, pk(-5760, 5715));
        w_start = 1'b1;
        tick();
        w_start = 1'b0;
        chk("busy_w_start_w_ready", w_ready, 0);
        chk("busy_w_start_weights_ok", weights_ok, 1);
        drain();
        for (int i = 0; i < TOTAL; i++) tb_w[i] = (i < NE) ? 1 : ((i == NE + 4) ? 1 : 0);
        load_w(TOTAL);
        send(mkwin(t1[0].e), 1'b0, pk(45, 5));
        drain();

        out_ready = 1'b0;
        send(mkwin(t1[1].e), 1'b0, pk(-18, -2));
        send(mkwin(t1[0].e), 1'b0, pk(45, 5));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_out_valid", out_valid, 1);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_weights_ok", weights_ok, 0);
        chk("midrst_win_ready", win_ready, 0);
        q_exp.delete();
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("post_rst_no_stale", seen, 0);
        load_w(TOTAL);
        send(mkwin(t1[3].e), 1'b0, pk(60, -50));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
